// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: ISA field constants,
// ALU operation codes and the controller state set.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUOP_ADD is the all-zero code so idle states naturally request an add
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_e;

endpackage

// File: rtl/mips_aludec.sv
// Combinational ALU decoder: maps the FSM's aluop request and the R-type
// funct field onto the 3-bit ALU operation code.
module mips_aludec
   import mips_pkg::*;
(
   input  aluop_e     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main Moore control FSM for the multicycle MIPS datapath; memory states
// stall on mem_ready and write strobes are masked while reset is low.
//
// state     | meaning
// FETCH     | read instr at PC, PC+4 -> PC, load IR (waits on mem_ready)
// DECODE    | read regs, branch target -> ALUOut, dispatch on opcode
// MEMADR    | rs + signext(imm) -> ALUOut
// MEMRD     | read memory at ALUOut (waits on mem_ready)
// MEMWB     | MDR -> rt
// MEMWR     | write rt to memory at ALUOut (waits on mem_ready)
// RTYPEEX   | rs op rt -> ALUOut
// RTYPEWB   | ALUOut -> rd
// BEQEX     | compare rs/rt, branch to ALUOut when equal
// ADDIEX    | rs + signext(imm) -> ALUOut
// ADDIWB    | ALUOut -> rt
// JEX       | jump target -> PC
module mips_multicycle_ctrl
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       irwrite,
   output logic       iord,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol
);

   state_e state, state_nxt;
   aluop_e aluop;
   logic   pcwrite, branch, irwrite_s, memwrite_s, regwrite_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = S_FETCH;
      aluop      = ALUOP_ADD;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite_s  = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      case (state)
         S_FETCH: begin
            alusrcb   = 2'b01;
            irwrite_s = mem_ready;
            pcwrite   = mem_ready;
            state_nxt = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_RTYPEEX;
               OP_BEQ:       state_nxt = S_BEQEX;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JEX;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord      = 1'b1;
            state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
            state_nxt  = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_RTYPEEX: begin
            alusrca   = 1'b1;
            aluop     = ALUOP_FUNCT;
            state_nxt = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            state_nxt = S_ADDIWB;
         end
         S_ADDIWB: regwrite_s = 1'b1;
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // Architectural writes are masked during reset so nothing half-done lands
   assign pcen     = reset & (pcwrite | (branch & zero));
   assign irwrite  = reset & irwrite_s;
   assign memwrite = reset & memwrite_s;
   assign regwrite = reset & regwrite_s;

   mips_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

endmodule
